riscuinho_control_fsm: RTL and testbench

- Multi-cycle sequencer for the RISCuinho integer core.
- Fetches an instruction over the instruction bus and latches it into the IR that feeds the integer instruction decoder.
- Consumes the decoder's control outputs and steps the datapath through DECODE, EXEC, optional MEM and WB.
- Raises halt on ECALL/EBREAK and traps on an illegal decode or a bus timeout. The PC and register file stay outside; this block only issues strobes.

---
 rtl/riscuinho_control_fsm_if.sv | 20 ++
 rtl/riscuinho_control_fsm.sv | 175 +++++++++++++++++
 tb/tb_riscuinho_control_fsm.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscuinho_control_fsm_if.sv
// Instruction and data bus handshake bundle for the RISCuinho control sequencer.
//   master (sequencer side): drives ibus_req, dbus_req, dbus_we; samples ibus_ack, dbus_ack
//   slave  (memory side)   : samples the requests; drives the acks
interface riscuinho_control_fsm_if;
  logic ibus_req;   // instruction fetch request
  logic ibus_ack;   // instruction data valid this cycle
  logic dbus_req;   // data bus request
  logic dbus_we;    // data bus write enable (store)
  logic dbus_ack;   // data bus acknowledge

  modport master (
    output ibus_req, dbus_req, dbus_we,
    input  ibus_ack, dbus_ack
  );

  modport slave (
    input  ibus_req, dbus_req, dbus_we,
    output ibus_ack, dbus_ack
  );
endinterface

// File: rtl/riscuinho_control_fsm.sv
// Multi-cycle sequencer for the RISCuinho integer core.
// Walks each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> WB, issuing
// strobes to the external IR, PC and register file. ECALL/EBREAK halts; an illegal
// decode or a bus that stays silent for BUS_TIMEOUT cycles traps. Both are terminal
// until reset.
// Ports:
//   clk, reset         core clock, synchronous active-high reset
//   bus                ibus/dbus handshake (master side)
//   ir_we              latch instruction register (same cycle as ibus_ack)
//   dec_*              decoder control outputs, branch_taken comparator result
//   reg_we, pc_we      register file / PC write strobes (WB only)
//   pc_sel             0: pc+4, 1: redirect target
//   halted, trap       sticky status, trap_cause 01 fetch TO, 10 data TO, 11 illegal
//   state              current FSM state (debug)
//   instret            retired-instruction count, wraps
module riscuinho_control_fsm #(
  parameter int BUS_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8,
  parameter int INSTRET_W   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  riscuinho_control_fsm_if.master       bus,
  output logic                          ir_we,
  input  logic                          dec_reg_w,
  input  logic                          dec_mem_r,
  input  logic                          dec_mem_w,
  input  logic                          dec_jump,
  input  logic                          dec_branch,
  input  logic                          branch_taken,
  input  logic                          dec_system,
  input  logic                          dec_illegal,
  output logic                          reg_we,
  output logic                          pc_we,
  output logic                          pc_sel,
  output logic                          halted,
  output logic                          trap,
  output logic [1:0]                    trap_cause,
  output logic [2:0]                    state,
  output logic [INSTRET_W-1:0]          instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] CAUSE_FETCH_TO = 2'b01;
  localparam logic [1:0] CAUSE_DATA_TO  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // A zero BUS_TIMEOUT disables the watchdog entirely.
  localparam bit                   TO_EN    = (BUS_TIMEOUT > 0);
  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  state_t                 state_reg, state_next;
  logic [TIMEOUT_W-1:0]   cnt_reg, cnt_next;
  logic [1:0]             cause_reg, cause_next;
  logic [INSTRET_W-1:0]   instret_reg, instret_next;
  logic                   wait_expired;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      cnt_reg     <= '0;
      cause_reg   <= 2'b00;
      instret_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cause_reg   <= cause_next;
      instret_reg <= instret_next;
    end
  end

  // The limit is reached on the last permitted waiting cycle; an ack in that
  // same cycle still takes priority over the trap.
  assign wait_expired = TO_EN && (cnt_reg == TO_LIMIT);

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cause_next   = cause_reg;
    instret_next = instret_reg;
    case (state_reg)
      S_FETCH: begin
        if (bus.ibus_ack) begin
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_FETCH_TO;
        end else if (TO_EN) begin
          cnt_next = cnt_reg + TIMEOUT_W'(1);
        end
      end
      S_DECODE: begin
        // A load and a store at once is not a real encoding: treat as illegal.
        if (dec_illegal || (dec_mem_r && dec_mem_w)) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (dec_system) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_next   = '0;
        state_next = (dec_mem_r || dec_mem_w) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.dbus_ack) begin
          state_next = S_WB;
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_DATA_TO;
        end else if (TO_EN) begin
          cnt_next = cnt_reg + TIMEOUT_W'(1);
        end
      end
      S_WB: begin
        cnt_next     = '0;
        instret_next = instret_reg + INSTRET_W'(1);
        state_next   = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  // Output logic; every request and strobe is held low while reset is asserted,
  // including the cycle in which reset arrives mid-transaction.
  always_comb begin
    bus.ibus_req = 1'b0;
    bus.dbus_req = 1'b0;
    bus.dbus_we  = 1'b0;
    ir_we        = 1'b0;
    reg_we       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          bus.ibus_req = 1'b1;
          ir_we        = bus.ibus_ack;
        end
        S_MEM: begin
          bus.dbus_req = 1'b1;
          bus.dbus_we  = dec_mem_w;
        end
        S_WB: begin
          reg_we = dec_reg_w;
          pc_we  = 1'b1;
          pc_sel = dec_jump | (dec_branch & branch_taken);
        end
        default: ;
      endcase
    end
  end

  assign halted     = (state_reg == S_HALT);
  assign trap       = (state_reg == S_TRAP);
  assign trap_cause = cause_reg;
  assign state      = state_reg;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_riscuinho_control_fsm.sv
// Self-checking bench for riscuinho_control_fsm with a short bus timeout (4) and a
// 4-bit retired counter so that timeouts and counter wrap are reachable quickly.
// Expected outputs come from the per-instruction timing rules: FETCH lasts until
// the ack (max 4 cycles), DECODE and EXEC one cycle each, MEM until the ack (max 4),
// WB one cycle; halts/traps are terminal.
module tb_riscuinho_control_fsm;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ir_we, reg_we, pc_we, pc_sel, halted, trap;
  logic       dec_reg_w = 0, dec_mem_r = 0, dec_mem_w = 0, dec_jump = 0;
  logic       dec_branch = 0, branch_taken = 0, dec_system = 0, dec_illegal = 0;
  logic [1:0] trap_cause;
  logic [2:0] state;
  logic [3:0] instret;

  riscuinho_control_fsm_if bus_if ();

  riscuinho_control_fsm #(
    .BUS_TIMEOUT (TO),
    .TIMEOUT_W   (3),
    .INSTRET_W   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .ir_we        (ir_we),
    .dec_reg_w    (dec_reg_w),
    .dec_mem_r    (dec_mem_r),
    .dec_mem_w    (dec_mem_w),
    .dec_jump     (dec_jump),
    .dec_branch   (dec_branch),
    .branch_taken (branch_taken),
    .dec_system   (dec_system),
    .dec_illegal  (dec_illegal),
    .reg_we       (reg_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .halted       (halted),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .state        (state),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_instr  = 0;
  logic [3:0] exp_instret = 4'd0;

  // Bit order: ibus_req ir_we dbus_req dbus_we reg_we pc_we pc_sel halted trap cause[1:0] state[2:0]
  logic [13:0] obs;
  assign obs = {bus_if.ibus_req, ir_we, bus_if.dbus_req, bus_if.dbus_we, reg_we, pc_we,
                pc_sel, halted, trap, trap_cause, state};

  function automatic logic [13:0] mk(input logic ireq, input logic irw, input logic dreq,
                                     input logic dwe, input logic rwe, input logic pwe,
                                     input logic psel, input logic hlt, input logic trp,
                                     input logic [1:0] cause, input logic [2:0] st);
    return {ireq, irw, dreq, dwe, rwe, pwe, psel, hlt, trp, cause, st};
  endfunction

  initial begin
    bus_if.ibus_ack = 1'b0;
    bus_if.dbus_ack = 1'b0;
  end

  // Tasks start and end at posedge+1 of a fresh cycle; outputs are sampled at negedge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_instret = 4'd0;
  endtask

  // Runs one instruction. fw/dw: wait cycles before ibus/dbus ack (>= TO means never).
  task automatic test_instr(input string name, input logic rw, input logic mr, input logic mw,
                            input logic jmp, input logic br, input logic bt, input logic sys,
                            input logic ill, input int fw, input int dw);
    int          outcome;  // 0 retire, 1 fetch TO, 2 data TO, 3 illegal, 4 halt
    int          cyc;
    logic [13:0] e;
    outcome = 0;
    cyc = 0;
    dec_reg_w = rw; dec_mem_r = mr; dec_mem_w = mw; dec_jump = jmp;
    dec_branch = br; branch_taken = bt; dec_system = sys; dec_illegal = ill;

    for (int i = 0; i <= fw && i < TO; i++) begin
      bus_if.ibus_ack = (i == fw);
      bus_if.dbus_ack = 1'($urandom_range(1, 0));
      @(negedge clk);
      e = mk(1'b1, (i == fw), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s fetch cycle %0d: outputs=%b required=%b", name, cyc, obs, e);
      end
      if (i == 0) begin
        n_checks++;
        if (instret !== exp_instret) begin
          n_fail++;
          $display("FAIL %s instret at fetch: got %0d required %0d", name, instret, exp_instret);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end

    if (fw >= TO) begin
      outcome = 1;
    end else begin
      bus_if.ibus_ack = 1'($urandom_range(1, 0));
      bus_if.dbus_ack = 1'($urandom_range(1, 0));
      @(negedge clk);
      e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd1);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s decode cycle %0d: outputs=%b required=%b", name, cyc, obs, e);
      end
      cyc++;
      @(posedge clk); #1;

      if (ill || (mr && mw))
        outcome = 3;
      else if (sys)
        outcome = 4;
      else begin
        bus_if.ibus_ack = 1'($urandom_range(1, 0));
        bus_if.dbus_ack = 1'($urandom_range(1, 0));
        @(negedge clk);
        e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd2);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL %s exec cycle %0d: outputs=%b required=%b", name, cyc, obs, e);
        end
        cyc++;
        @(posedge clk); #1;

        if (mr || mw) begin
          for (int i = 0; i <= dw && i < TO; i++) begin
            bus_if.dbus_ack = (i == dw);
            bus_if.ibus_ack = 1'($urandom_range(1, 0));
            @(negedge clk);
            e = mk(1'b0, 1'b0, 1'b1, mw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd3);
            n_checks++;
            if (obs !== e) begin
              n_fail++;
              $display("FAIL %s mem cycle %0d: outputs=%b required=%b", name, cyc, obs, e);
            end
            cyc++;
            @(posedge clk); #1;
          end
          if (dw >= TO) outcome = 2;
        end

        if (outcome == 0) begin
          bus_if.ibus_ack = 1'($urandom_range(1, 0));
          bus_if.dbus_ack = 1'($urandom_range(1, 0));
          @(negedge clk);
          e = mk(1'b0, 1'b0, 1'b0, 1'b0, rw, 1'b1, jmp | (br & bt), 1'b0, 1'b0, 2'b00, 3'd4);
          n_checks++;
          if (obs !== e) begin
            n_fail++;
            $display("FAIL %s wb cycle %0d: outputs=%b required=%b", name, cyc, obs, e);
          end
          n_checks++;
          if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL %s instret at wb: got %0d required %0d", name, instret, exp_instret);
          end
          exp_instret = exp_instret + 4'd1;
          cyc++;
          @(posedge clk); #1;
        end
      end
    end

    // Halt/trap are terminal: stay put, no strobes, instret frozen, acks ignored.
    if (outcome != 0) begin
      for (int k = 0; k < 3; k++) begin
        bus_if.ibus_ack = 1'($urandom_range(1, 0));
        bus_if.dbus_ack = 1'($urandom_range(1, 0));
        @(negedge clk);
        if (outcome == 4)
          e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd5);
        else
          e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'(outcome), 3'd6);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL %s terminal cycle %0d: outputs=%b required=%b", name, k, obs, e);
        end
        n_checks++;
        if (instret !== exp_instret) begin
          n_fail++;
          $display("FAIL %s instret terminal: got %0d required %0d", name, instret, exp_instret);
        end
        @(posedge clk); #1;
      end
    end
    bus_if.ibus_ack = 1'b0;
    bus_if.dbus_ack = 1'b0;
    $display("instr %0d %s fetch_wait=%0d mem_wait=%0d outcome=%0d cycles=%0d instret=%0d",
             n_instr, name, fw, dw, outcome, cyc, exp_instret);
    n_instr++;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    reset = 1'b1;
    bus_if.ibus_ack = 1'b1;
    bus_if.dbus_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset outputs: got %b required %b", obs, e);
    end
    n_checks++;
    if (instret !== 4'd0) begin
      n_fail++;
      $display("FAIL reset instret: got %0d required 0", instret);
    end
    @(posedge clk); #1;
    bus_if.ibus_ack = 1'b0;
    bus_if.dbus_ack = 1'b0;
    reset = 1'b0;
    exp_instret = 4'd0;
    $display("reset sequence done");
  endtask

  task automatic test_alu();
    test_instr("add", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_store();
    test_instr("lw", 1, 1, 0, 0, 0, 0, 0, 0, 0, 3);
    test_instr("sw", 0, 0, 1, 0, 0, 0, 0, 0, $urandom_range(3, 0), $urandom_range(3, 0));
  endtask

  task automatic test_branch();
    test_instr("beq_taken", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    test_instr("beq_not_taken", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    test_instr("jal", 1, 0, 0, 1, 0, 1'($urandom_range(1, 0)), 0, 0, 2, 0);
  endtask

  task automatic test_random_stream();
    for (int n = 0; n < 40; n++) begin
      int   cls;
      logic rw, jmp, br, bt;
      cls = $urandom_range(2, 0);
      rw  = 1'($urandom_range(1, 0));
      jmp = 1'($urandom_range(1, 0));
      br  = 1'($urandom_range(1, 0));
      bt  = 1'($urandom_range(1, 0));
      test_instr("rand", rw, (cls == 1), (cls == 2), jmp, br, bt, 0, 0,
                 $urandom_range(TO - 1, 0), $urandom_range(TO - 1, 0));
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [13:0] e;
    test_instr("add_pre", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dec_mem_r = 1'b1; dec_mem_w = 1'b0; dec_reg_w = 1'b1;
    dec_system = 1'b0; dec_illegal = 1'b0;
    bus_if.ibus_ack = 1'b1;
    @(posedge clk); #1;            // now DECODE
    bus_if.ibus_ack = 1'b0;
    @(posedge clk); #1;            // now EXEC
    @(posedge clk); #1;            // now MEM, no ack
    reset = 1'b1;
    @(negedge clk);
    e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd3);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_mid_mem during reset: got %b required %b", obs, e);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_instret = 4'd0;
    @(negedge clk);
    e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_mid_mem after reset: got %b required %b", obs, e);
    end
    n_checks++;
    if (instret !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mem instret: got %0d required 0", instret);
    end
    @(posedge clk); #1;
    $display("reset mid-MEM sequence done");
    do_reset();
  endtask

  task automatic test_halt();
    test_instr("add_pre", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_instr("ecall", 0, 0, 0, 0, 0, 0, 1, 0, $urandom_range(TO - 1, 0), 0);
    do_reset();
  endtask

  task automatic test_illegal();
    test_instr("illegal", 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    do_reset();
    test_instr("load_and_store", 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    do_reset();
  endtask

  task automatic test_timeouts();
    test_instr("fetch_timeout", 1, 0, 0, 0, 0, 0, 0, 0, 100, 0);
    do_reset();
    test_instr("mem_timeout", 1, 1, 0, 0, 0, 0, 0, 0, 0, 100);
    do_reset();
    test_instr("ack_at_limit", 0, 0, 1, 0, 0, 0, 0, 0, TO - 1, TO - 1);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_random_stream();
    test_reset_mid_mem();
    test_halt();
    test_illegal();
    test_timeouts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
